id_operand_stage: RTL and testbench
===================================

# id_operand_stage

Decode-side operand stage of the 5-stage MIPS pipeline; sits between the IF/ID boundary and the ID/EX pipeline register, directly downstream of the forwarding unit. Holds the fetched instruction across stalls, drives register-file and forwarding read addresses, and merges forwarded data over register-file data. Detects load-use hazards and raises a one-cycle stall request. Registers the resolved bundle into ID/EX with bubble insertion.

## Interface
- DATA_W, 32, datapath and instruction width
- RADDR_W, 5, register address width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  stall vector [5:0] = {WB,MEM,EX,ID,IF,PC}; 1 = Stop
- if_valid  in  1  IF/ID slot holds a real instruction
- if_pc  in  DATA_W  PC of instruction in ID
- inst_sram_rdata  in  DATA_W  instruction word; valid only in the first cycle the instruction is in ID
- rs_rdata, rt_rdata  in  DATA_W  register-file read data
- sel_rs_forward, sel_rt_forward  in  1  forward select, aligned to the ID instruction
- rs_forward_data, rt_forward_data  in  DATA_W  forwarded values
- ex_is_load  in  1  instruction in EX is a load
- ex_waddr  in  RADDR_W  destination of EX instruction
- rs_raddr, rt_raddr  out  RADDR_W  inst[25:21], inst[20:16] of current instruction (combinational)
- stallreq_id  out  1  load-use stall request to stall controller
- id_ex_valid  out  1  registered
- id_ex_pc, id_ex_inst, id_ex_rs_val, id_ex_rt_val  out  DATA_W  registered

## Operation
- Current instruction cur_inst = buf_valid ? inst_buf : inst_sram_rdata.
- Instruction buffer: first cycle with stall[2]=1 and buf_valid=0 → inst_buf <= inst_sram_rdata, buf_valid <= 1. Cleared (buf_valid <= 0) in any cycle with stall[2]=0.
- Operands: rs_val = sel_rs_forward ? rs_forward_data : rs_rdata; same for rt. Address 0 always yields 0 regardless of forward inputs.
- Load-use hit: if_valid & ex_is_load & ex_waddr≠0 & (rs_raddr==ex_waddr | rt_raddr==ex_waddr). Both fields compared unconditionally (over-stall permitted, under-stall never).
- FSM, states RUN, LOAD_WAIT, HOLD:
  - RUN: load-use hit → stallreq_id=1 (combinational), next LOAD_WAIT. Else stall[2]=1 → HOLD.
  - LOAD_WAIT: stallreq_id=0; next RUN if stall[2]=0, else HOLD. Hit never re-raised in this state.
  - HOLD: stallreq_id=0; next RUN when stall[2]=0.
- ID/EX register, priority order: rst → all zero; stall[2]=1 & stall[3]=0 → bubble (all zero); stall[2]=0 → load {if_valid, if_pc, cur_inst, rs_val, rt_val}; otherwise hold.

## Timing
- Reset: state RUN, buf_valid 0, inst_buf 0, all id_ex_* 0; stallreq_id 0 in cycle after reset.
- Latency ID→EX one cycle; stallreq_id same-cycle, exactly one cycle high per load-use hit.
- Load-use: hit cycle N → bubble in EX at N+1, instruction advances at N+1 edge with MEM-forwarded value.
- Stall lasting k cycles: instruction word captured at first stalled edge, presented unchanged for all k cycles and on the release edge.
- Simultaneous hit and external stall[2]: stallreq_id still 1; next state LOAD_WAIT.
- rst mid-stall: buffer, FSM and ID/EX cleared that edge; rst dominates stall.

## Configuration
- LOAD_USE_STALL_EN defined: detection and LOAD_WAIT as above.
- Undefined: stallreq_id tied 0, LOAD_WAIT unreachable, ex_is_load/ex_waddr unused; buffer and ID/EX behaviour unchanged.

## Structure
- Shared package cpu_defs_pkg: stall vector width, Stop/NoStop constants, stall index names, FSM state enum.
- One sub-module id_inst_buffer (capture/clear of inst_buf, buf_valid, cur_inst mux); FSM, operand mux and ID/EX register in the top.

## Test plan
- Reset with stall=6'h3F, inst 0xFFFFFFFF → all id_ex_* 0, stallreq_id 0, buf_valid 0.
- lw $t0 in EX (ex_waddr=8), ID inst addu $t1,$t0,$t2 (0x010A4821) → stallreq_id 1 for one cycle; id_ex_valid 0 next cycle; then id_ex_inst 0x010A4821 with rs_val = forwarded 0x12345678.
- stall=6'b000111 for 3 cycles, inst_sram_rdata changes to 0xDEADBEEF after first → id_ex_inst after release equals original word.
- sel_rs_forward=1, rs_forward_data=0xA5A5A5A5, rs_rdata=0x1 → id_ex_rs_val 0xA5A5A5A5; rs_raddr=0 with forward → 0.
- ex_is_load=1, ex_waddr=0, rs_raddr=0 → no stall request.
- rst asserted in cycle 2 of a 4-cycle stall → buffer cleared, FSM RUN, id_ex_* 0 next cycle.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths, stall vector layout, ID-stage FSM states and the ID/EX bundle.
package cpu_defs_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned STALL_W = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Stall vector bit positions, {WB,MEM,EX,ID,IF,PC}
  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_HOLD      = 2'd2
  } id_state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
  } id_ex_t;

  // Forwarded data wins over register-file data; $zero always reads as 0.
  function automatic logic [DATA_W-1:0] sel_operand(
    input logic [RADDR_W-1:0] addr,
    input logic               sel_fwd,
    input logic [DATA_W-1:0]  fwd_data,
    input logic [DATA_W-1:0]  rf_data
  );
    if (addr == '0) return '0;
    return sel_fwd ? fwd_data : rf_data;
  endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Bus between the ID operand stage and its surroundings (stall control, regfile, forwarding, ID/EX consumers).
interface id_operand_stage_if;
  import cpu_defs_pkg::*;

  logic [STALL_W-1:0] stall;
  logic               if_valid;
  logic [DATA_W-1:0]  if_pc;
  logic [DATA_W-1:0]  inst_sram_rdata;
  logic [DATA_W-1:0]  rs_rdata;
  logic [DATA_W-1:0]  rt_rdata;
  logic               sel_rs_forward;
  logic               sel_rt_forward;
  logic [DATA_W-1:0]  rs_forward_data;
  logic [DATA_W-1:0]  rt_forward_data;
  logic               ex_is_load;
  logic [RADDR_W-1:0] ex_waddr;

  logic [RADDR_W-1:0] rs_raddr;
  logic [RADDR_W-1:0] rt_raddr;
  logic               stallreq_id;
  logic               id_ex_valid;
  logic [DATA_W-1:0]  id_ex_pc;
  logic [DATA_W-1:0]  id_ex_inst;
  logic [DATA_W-1:0]  id_ex_rs_val;
  logic [DATA_W-1:0]  id_ex_rt_val;

  modport master (
    output stall, if_valid, if_pc, inst_sram_rdata, rs_rdata, rt_rdata,
           sel_rs_forward, sel_rt_forward, rs_forward_data, rt_forward_data,
           ex_is_load, ex_waddr,
    input  rs_raddr, rt_raddr, stallreq_id, id_ex_valid, id_ex_pc, id_ex_inst,
           id_ex_rs_val, id_ex_rt_val
  );

  modport slave (
    input  stall, if_valid, if_pc, inst_sram_rdata, rs_rdata, rt_rdata,
           sel_rs_forward, sel_rt_forward, rs_forward_data, rt_forward_data,
           ex_is_load, ex_waddr,
    output rs_raddr, rt_raddr, stallreq_id, id_ex_valid, id_ex_pc, id_ex_inst,
           id_ex_rs_val, id_ex_rt_val
  );

endinterface

// File: rtl/id_inst_buffer.sv
// Holds the instruction word across ID stalls; the SRAM word is only valid in the first ID cycle.
module id_inst_buffer
  import cpu_defs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_id,
  input  logic [DATA_W-1:0] inst_sram_rdata,
  output logic              buf_valid,
  output logic [DATA_W-1:0] cur_inst_c
);

  logic [DATA_W-1:0] inst_buf;

  // Capture on the first stalled edge, drop the copy as soon as ID moves again.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_buf  <= '0;
      buf_valid <= 1'b0;
    end else if (!stall_id) begin
      buf_valid <= 1'b0;
    end else if (!buf_valid) begin
      inst_buf  <= inst_sram_rdata;
      buf_valid <= 1'b1;
    end
  end

  assign cur_inst_c = buf_valid ? inst_buf : inst_sram_rdata;

endmodule

// File: rtl/id_operand_stage.sv
// ID operand stage: instruction hold, operand merge, load-use stall request and ID/EX register.
// Optional build macro LOAD_USE_STALL_EN enables load-use detection and the LOAD_WAIT state.
module id_operand_stage
  import cpu_defs_pkg::*;
(
  input logic              clk,
  input logic              rst,
  id_operand_stage_if.slave bus
);

  logic              stall_id;
  logic              stall_ex;
  logic              buf_valid;
  logic [DATA_W-1:0] cur_inst;
  logic              load_use_hit;
  logic              stallreq_c;
  id_state_e         state;
  id_state_e         state_nxt;
  id_ex_t            id_ex_q;
  id_ex_t            id_ex_d;

  assign stall_id = (bus.stall[STALL_ID] == STOP);
  assign stall_ex = (bus.stall[STALL_EX] == STOP);

  id_inst_buffer u_buf (
    .clk             (clk),
    .rst             (rst),
    .stall_id        (stall_id),
    .inst_sram_rdata (bus.inst_sram_rdata),
    .buf_valid       (buf_valid),
    .cur_inst_c      (cur_inst)
  );

  assign bus.rs_raddr = cur_inst[25:21];
  assign bus.rt_raddr = cur_inst[20:16];

  // Both fields compared regardless of format: over-stalling is harmless, under-stalling is not.
`ifdef LOAD_USE_STALL_EN
  assign load_use_hit = bus.if_valid && bus.ex_is_load && (bus.ex_waddr != '0) &&
                        ((bus.rs_raddr == bus.ex_waddr) || (bus.rt_raddr == bus.ex_waddr));
`else
  assign load_use_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    stallreq_c = 1'b0;
    case (state)
      ST_RUN: begin
        if (load_use_hit) begin
          stallreq_c = 1'b1;
          state_nxt  = ST_LOAD_WAIT;
        end else if (stall_id) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_LOAD_WAIT: state_nxt = stall_id ? ST_HOLD : ST_RUN;
      ST_HOLD:      if (!stall_id) state_nxt = ST_RUN;
      default:      state_nxt = ST_RUN;
    endcase
  end

  assign bus.stallreq_id = stallreq_c;

  always_comb begin
    id_ex_d.valid  = bus.if_valid;
    id_ex_d.pc     = bus.if_pc;
    id_ex_d.inst   = cur_inst;
    id_ex_d.rs_val = sel_operand(bus.rs_raddr, bus.sel_rs_forward, bus.rs_forward_data, bus.rs_rdata);
    id_ex_d.rt_val = sel_operand(bus.rt_raddr, bus.sel_rt_forward, bus.rt_forward_data, bus.rt_rdata);
  end

  // ID stalled with EX free inserts a bubble; both stalled holds the slot.
  always_ff @(posedge clk) begin
    if (rst)                      id_ex_q <= '0;
    else if (stall_id && !stall_ex) id_ex_q <= '0;
    else if (!stall_id)           id_ex_q <= id_ex_d;
  end

  assign bus.id_ex_valid  = id_ex_q.valid;
  assign bus.id_ex_pc     = id_ex_q.pc;
  assign bus.id_ex_inst   = id_ex_q.inst;
  assign bus.id_ex_rs_val = id_ex_q.rs_val;
  assign bus.id_ex_rt_val = id_ex_q.rt_val;

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage; expectations follow LOAD_USE_STALL_EN when it is defined.
module tb_id_operand_stage;
  import cpu_defs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  id_operand_stage_if bus ();

  id_operand_stage u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.stall           = 6'b0;
    bus.if_valid        = 1'b0;
    bus.if_pc           = 32'h0;
    bus.inst_sram_rdata = 32'h0;
    bus.rs_rdata        = 32'h0;
    bus.rt_rdata        = 32'h0;
    bus.sel_rs_forward  = 1'b0;
    bus.sel_rt_forward  = 1'b0;
    bus.rs_forward_data = 32'h0;
    bus.rt_forward_data = 32'h0;
    bus.ex_is_load      = 1'b0;
    bus.ex_waddr        = 5'd0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    bus.stall = 6'h3F;
    bus.if_valid = 1'b1;
    bus.if_pc = 32'h40;
    bus.inst_sram_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    checks++; if (bus.id_ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.id_ex_valid); end
    checks++; if (bus.id_ex_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.id_ex_pc); end
    checks++; if (bus.id_ex_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", bus.id_ex_inst); end
    checks++; if (bus.id_ex_rs_val !== 32'h0 || bus.id_ex_rt_val !== 32'h0) begin errors++; $display("FAIL reset_vals: got %h/%h expected 0/0", bus.id_ex_rs_val, bus.id_ex_rt_val); end
    checks++; if (bus.stallreq_id !== 1'b0) begin errors++; $display("FAIL reset_stallreq: got %0b expected 0", bus.stallreq_id); end
    checks++; if (u_dut.buf_valid !== 1'b0) begin errors++; $display("FAIL reset_buf_valid: got %0b expected 0", u_dut.buf_valid); end
    checks++; if (bus.rs_raddr !== 5'd31) begin errors++; $display("FAIL reset_rs_raddr: got %0d expected 31", bus.rs_raddr); end
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    checks++; if (bus.stallreq_id !== 1'b0) begin errors++; $display("FAIL post_reset_stallreq: got %0b expected 0", bus.stallreq_id); end
  endtask

  task automatic test_load_use();
    drive_idle();
    bus.if_valid        = 1'b1;
    bus.if_pc           = 32'h0000_0200;
    bus.inst_sram_rdata = 32'h010A_4821;
    bus.rs_rdata        = 32'h0000_0011;
    bus.rt_rdata        = 32'h0000_0022;
    bus.ex_is_load      = 1'b1;
    bus.ex_waddr        = 5'd8;
`ifdef LOAD_USE_STALL_EN
    #1;
    checks++; if (bus.stallreq_id !== 1'b1) begin errors++; $display("FAIL lu_stallreq_hit: got %0b expected 1", bus.stallreq_id); end
    bus.stall = 6'b000111;
    @(negedge clk);
    checks++; if (bus.id_ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble: got %0b expected 0", bus.id_ex_valid); end
    checks++; if (bus.stallreq_id !== 1'b0) begin errors++; $display("FAIL lu_no_reraise: got %0b expected 0", bus.stallreq_id); end
    bus.stall           = 6'b0;
    bus.inst_sram_rdata = 32'hFFFF_FFFF;
    bus.sel_rs_forward  = 1'b1;
    bus.rs_forward_data = 32'h1234_5678;
    @(negedge clk);
    checks++; if (u_dut.state !== ST_RUN) begin errors++; $display("FAIL lu_state_run: got %0d expected %0d", u_dut.state, ST_RUN); end
`else
    bus.sel_rs_forward  = 1'b1;
    bus.rs_forward_data = 32'h1234_5678;
    #1;
    checks++; if (bus.stallreq_id !== 1'b0) begin errors++; $display("FAIL lu_stallreq_disabled: got %0b expected 0", bus.stallreq_id); end
    @(negedge clk);
`endif
    checks++; if (bus.id_ex_valid !== 1'b1) begin errors++; $display("FAIL lu_valid: got %0b expected 1", bus.id_ex_valid); end
    checks++; if (bus.id_ex_inst !== 32'h010A_4821) begin errors++; $display("FAIL lu_inst: got %h expected 010a4821", bus.id_ex_inst); end
    checks++; if (bus.id_ex_rs_val !== 32'h1234_5678) begin errors++; $display("FAIL lu_rs_val: got %h expected 12345678", bus.id_ex_rs_val); end
    checks++; if (bus.id_ex_rt_val !== 32'h0000_0022) begin errors++; $display("FAIL lu_rt_val: got %h expected 00000022", bus.id_ex_rt_val); end
    checks++; if (bus.id_ex_pc !== 32'h0000_0200) begin errors++; $display("FAIL lu_pc: got %h expected 00000200", bus.id_ex_pc); end
  endtask

`ifdef LOAD_USE_STALL_EN
  task automatic test_hit_with_stall();
    drive_idle();
    bus.if_valid        = 1'b1;
    bus.inst_sram_rdata = 32'h010A_4821;
    bus.ex_is_load      = 1'b1;
    bus.ex_waddr        = 5'd10;
    bus.stall           = 6'b000111;
    #1;
    checks++; if (bus.stallreq_id !== 1'b1) begin errors++; $display("FAIL hs_stallreq: got %0b expected 1", bus.stallreq_id); end
    @(negedge clk);
    checks++; if (u_dut.state !== ST_LOAD_WAIT) begin errors++; $display("FAIL hs_state: got %0d expected %0d", u_dut.state, ST_LOAD_WAIT); end
    bus.stall = 6'b0;
    bus.ex_is_load = 1'b0;
    @(negedge clk);
  endtask
`endif

  task automatic test_stall_hold();
    drive_idle();
    bus.if_valid        = 1'b1;
    bus.if_pc           = 32'h0000_0100;
    bus.inst_sram_rdata = 32'h8C88_0004;
    bus.rs_rdata        = 32'h0000_0005;
    bus.rt_rdata        = 32'h0000_0006;
    bus.stall           = 6'b000111;
    @(negedge clk);
    checks++; if (bus.id_ex_valid !== 1'b0) begin errors++; $display("FAIL sh_bubble: got %0b expected 0", bus.id_ex_valid); end
    bus.inst_sram_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.rs_raddr !== 5'd4 || bus.rt_raddr !== 5'd8) begin errors++; $display("FAIL sh_raddr_held: got %0d/%0d expected 4/8", bus.rs_raddr, bus.rt_raddr); end
    repeat (2) @(negedge clk);
    bus.stall = 6'b0;
    @(negedge clk);
    checks++; if (bus.id_ex_inst !== 32'h8C88_0004) begin errors++; $display("FAIL sh_inst: got %h expected 8c880004", bus.id_ex_inst); end
    checks++; if (bus.id_ex_rs_val !== 32'h5 || bus.id_ex_rt_val !== 32'h6) begin errors++; $display("FAIL sh_vals: got %h/%h expected 5/6", bus.id_ex_rs_val, bus.id_ex_rt_val); end
    checks++; if (u_dut.buf_valid !== 1'b0) begin errors++; $display("FAIL sh_buf_cleared: got %0b expected 0", u_dut.buf_valid); end
    bus.stall = 6'b001111;
    bus.inst_sram_rdata = 32'h1111_1111;
    @(negedge clk);
    checks++; if (bus.id_ex_inst !== 32'h8C88_0004 || bus.id_ex_valid !== 1'b1) begin errors++; $display("FAIL sh_ex_hold: got %h/%0b expected 8c880004/1", bus.id_ex_inst, bus.id_ex_valid); end
    bus.stall = 6'b0;
    @(negedge clk);
  endtask

  task automatic test_forward();
    drive_idle();
    bus.if_valid        = 1'b1;
    bus.inst_sram_rdata = 32'h012A_4021;
    bus.sel_rs_forward  = 1'b1;
    bus.rs_forward_data = 32'hA5A5_A5A5;
    bus.rs_rdata        = 32'h0000_0001;
    bus.rt_rdata        = 32'h0000_0022;
    bus.rt_forward_data = 32'h9999_9999;
    @(negedge clk);
    checks++; if (bus.id_ex_rs_val !== 32'hA5A5_A5A5) begin errors++; $display("FAIL fw_rs: got %h expected a5a5a5a5", bus.id_ex_rs_val); end
    checks++; if (bus.id_ex_rt_val !== 32'h0000_0022) begin errors++; $display("FAIL fw_rt_rf: got %h expected 00000022", bus.id_ex_rt_val); end
    bus.inst_sram_rdata = 32'h000A_4021;
    @(negedge clk);
    checks++; if (bus.id_ex_rs_val !== 32'h0) begin errors++; $display("FAIL fw_rs_zero: got %h expected 0", bus.id_ex_rs_val); end
    bus.inst_sram_rdata = 32'h0;
    bus.sel_rt_forward  = 1'b1;
    @(negedge clk);
    checks++; if (bus.id_ex_rs_val !== 32'h0 || bus.id_ex_rt_val !== 32'h0) begin errors++; $display("FAIL fw_both_zero: got %h/%h expected 0/0", bus.id_ex_rs_val, bus.id_ex_rt_val); end
  endtask

  task automatic test_zero_dest();
    drive_idle();
    bus.if_valid        = 1'b1;
    bus.inst_sram_rdata = 32'h0;
    bus.ex_is_load      = 1'b1;
    bus.ex_waddr        = 5'd0;
    #1;
    checks++; if (bus.stallreq_id !== 1'b0) begin errors++; $display("FAIL zd_stallreq: got %0b expected 0", bus.stallreq_id); end
    bus.if_valid        = 1'b0;
    bus.inst_sram_rdata = 32'h010A_4821;
    bus.ex_waddr        = 5'd8;
    #1;
    checks++; if (bus.stallreq_id !== 1'b0) begin errors++; $display("FAIL zd_invalid_slot: got %0b expected 0", bus.stallreq_id); end
    bus.ex_is_load      = 1'b0;
    bus.if_valid        = 1'b1;
    bus.if_pc           = 32'h0000_0300;
    @(negedge clk);
  endtask

  task automatic test_rst_mid_stall();
    drive_idle();
    bus.if_valid        = 1'b1;
    bus.if_pc           = 32'h0000_0400;
    bus.inst_sram_rdata = 32'h1111_1111;
    bus.stall           = 6'b001111;
    @(negedge clk);
    checks++; if (u_dut.buf_valid !== 1'b1) begin errors++; $display("FAIL rs_buf_captured: got %0b expected 1", u_dut.buf_valid); end
    rst = 1'b1;
    bus.inst_sram_rdata = 32'h2222_2222;
    @(negedge clk);
    checks++; if (u_dut.buf_valid !== 1'b0) begin errors++; $display("FAIL rs_buf_cleared: got %0b expected 0", u_dut.buf_valid); end
    checks++; if (u_dut.state !== ST_RUN) begin errors++; $display("FAIL rs_state: got %0d expected %0d", u_dut.state, ST_RUN); end
    checks++; if (bus.id_ex_valid !== 1'b0 || bus.id_ex_inst !== 32'h0 || bus.id_ex_pc !== 32'h0) begin errors++; $display("FAIL rs_id_ex: got %0b/%h/%h expected 0/0/0", bus.id_ex_valid, bus.id_ex_inst, bus.id_ex_pc); end
    checks++; if (bus.rs_raddr !== 5'd17) begin errors++; $display("FAIL rs_raddr_live: got %0d expected 17", bus.rs_raddr); end
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_load_use();
`ifdef LOAD_USE_STALL_EN
    test_hit_with_stall();
`endif
    test_stall_hold();
    test_forward();
    test_zero_dest();
    test_rst_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
